imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, 32, immediate/datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter CNT_W, 8, width of the illegal-opcode counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an instruction this cycle.
REQ-007 SHALL have port in_instr  input  32  raw instruction word.
REQ-008 SHALL have port out_valid  output  1  out_imm, out_fmt and out_illegal are valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the output this cycle.
REQ-010 SHALL have port out_imm  output  XLEN  sign-extended immediate.
REQ-011 SHALL have port out_fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
REQ-012 SHALL have port out_illegal  output  1  opcode is not a recognised RV32I opcode.
REQ-013 SHALL have port err_cnt  output  CNT_W  saturating count of illegal opcodes accepted.

Function
REQ-014 Decode SHALL use in_instr[6:0] as follows: 0010011/0000011/1100111/1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 0110011 -> R; any other value -> NONE, illegal.
REQ-015 Immediates SHALL be formed as follows:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All formats SHALL be sign-extended from instr[31] to XLEN; R and NONE SHALL give 0.
REQ-016 A transfer SHALL occur on any cycle with in_valid && in_ready; output-side transfer on out_valid && out_ready.
REQ-017 Latency SHALL be exactly 1 cycle from input transfer to out_valid when the output register is empty or draining.
REQ-018 The block SHALL contain an output register plus a 1-entry skid register and sustain one transfer per cycle under continuous out_ready=1.
REQ-019 in_ready SHALL equal !skid_full, driven from a register with no combinational path from out_ready.
REQ-020 On input transfer while the output is held (out_valid && !out_ready), the decoded result SHALL go into the skid register.
REQ-021 When the output transfers and the skid register is full, the skid contents SHALL move to the output register next cycle and skid SHALL become empty.
REQ-022 Outputs SHALL stay stable while out_valid && !out_ready.
REQ-023 Ordering SHALL be strictly preserved; no entry SHALL be dropped or duplicated.
REQ-024 err_cnt SHALL increment by 1 on each input transfer with an illegal opcode, saturate at all-ones and never wrap.
REQ-025 in_instr SHALL be ignored whenever in_ready=0.

Reset
REQ-026 While reset=1, the block SHALL hold: out_valid=0, skid empty, in_ready=0, out_imm=0, out_fmt=7, out_illegal=0, err_cnt=0.
REQ-027 On reset assertion mid-operation, all in-flight entries SHALL be discarded immediately (asynchronously).
REQ-028 in_ready SHALL rise in the first clk edge after reset deasserts.

Structure
REQ-029 Format codes and opcode constants SHALL reside in the shared package imm_pkg, which is reused by the decoder and ALU control.
REQ-030 Decode SHALL be a combinational sub-module imm_decode (instr -> imm, fmt, illegal), instantiated once at the input; the registered stages SHALL store decoded values.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
  - in_instr 0xFFF00093, out_ready=1 -> next cycle out_imm 0xFFFFFFFF, fmt 1.
  - 0xFE112E23 -> imm 0xFFFFFFFC, fmt 2.
  - 0xFE000CE3 -> imm 0xFFFFFFF8, fmt 3.
  - 0x123450B7 -> imm 0x12345000, fmt 4.
  - XLEN=64, 0xFFF00093 -> imm 0xFFFFFFFFFFFFFFFF.
  - Back-to-back A, B, C with out_ready=0 for 3 cycles -> A held, B in skid, in_ready=0, C stalled; out_ready=1 -> A, B, C in order, no loss.
  - 0x0000007F ×300 with CNT_W=8 -> out_illegal=1, fmt 7, imm 0, err_cnt saturates at 255.
  - reset pulse while out_valid=1 and skid full -> out_valid=0, err_cnt=0 immediately; in_ready=1 after the first post-reset edge.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared RV32I opcode constants and immediate format codes.
// Used by the immediate decoder and by ALU control.
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_NONE = 3'd7
   } fmt_e;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   function automatic logic is_itype(input logic [6:0] op);
      return (op == OP_IMM) || (op == OP_LOAD) ||
             (op == OP_JALR) || (op == OP_SYSTEM);
   endfunction

   function automatic logic is_utype(input logic [6:0] op);
      return (op == OP_LUI) || (op == OP_AUIPC);
   endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I immediate decoder.
// Produces the sign-extended immediate, format and illegal flag.
module imm_decode
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output fmt_e            fmt,
   output logic            illegal
);

   logic [6:0]  op;
   logic [31:0] raw;

   assign op = instr[6:0];

   // Pick the format and build the 32-bit immediate for it.
   always_comb begin
      fmt     = FMT_NONE;
      illegal = 1'b0;
      raw     = '0;
      unique case (1'b1)
         is_itype(op): begin
            fmt = FMT_I;
            raw = {{20{instr[31]}}, instr[31:20]};
         end
         (op == OP_STORE): begin
            fmt = FMT_S;
            raw = {{20{instr[31]}}, instr[31:25],
                   instr[11:7]};
         end
         (op == OP_BRANCH): begin
            fmt = FMT_B;
            raw = {{19{instr[31]}}, instr[31],
                   instr[7], instr[30:25],
                   instr[11:8], 1'b0};
         end
         is_utype(op): begin
            fmt = FMT_U;
            raw = {instr[31:12], 12'b0};
         end
         (op == OP_JAL): begin
            fmt = FMT_J;
            raw = {{11{instr[31]}}, instr[31],
                   instr[19:12], instr[20],
                   instr[30:21], 1'b0};
         end
         (op == OP_OP): begin
            fmt = FMT_R;
         end
         default: begin
            fmt     = FMT_NONE;
            illegal = 1'b1;
         end
      endcase
   end

   // All 32-bit immediates carry instr[31] as their sign bit.
   assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with output register and skid slot.
// in_ready is registered so it never depends on out_ready.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [XLEN-1:0]  dec_imm;
   fmt_e             dec_fmt;
   logic             dec_ill;

   logic             rdy_q;
   logic             ov_q,    ov_d;
   logic [XLEN-1:0]  o_imm_q, o_imm_d;
   fmt_e             o_fmt_q, o_fmt_d;
   logic             o_ill_q, o_ill_d;
   logic             sv_q,    sv_d;
   logic [XLEN-1:0]  s_imm_q, s_imm_d;
   fmt_e             s_fmt_q, s_fmt_d;
   logic             s_ill_q, s_ill_d;
   logic [CNT_W-1:0] cnt_q;

   logic             in_fire;
   logic             out_load;

   imm_decode #(
      .XLEN (XLEN)
   ) u_dec (
      .instr   (in_instr),
      .imm     (dec_imm),
      .fmt     (dec_fmt),
      .illegal (dec_ill)
   );

   assign in_fire  = in_valid && rdy_q;
   assign out_load = !ov_q || out_ready;

   // Steer decoded entries into the output register or the skid slot.
   always_comb begin
      ov_d    = ov_q;
      o_imm_d = o_imm_q;
      o_fmt_d = o_fmt_q;
      o_ill_d = o_ill_q;
      sv_d    = sv_q;
      s_imm_d = s_imm_q;
      s_fmt_d = s_fmt_q;
      s_ill_d = s_ill_q;
      if (out_load) begin
         if (sv_q) begin
            ov_d    = 1'b1;
            o_imm_d = s_imm_q;
            o_fmt_d = s_fmt_q;
            o_ill_d = s_ill_q;
            sv_d    = in_fire;
            if (in_fire) begin
               s_imm_d = dec_imm;
               s_fmt_d = dec_fmt;
               s_ill_d = dec_ill;
            end
         end else if (in_fire) begin
            ov_d    = 1'b1;
            o_imm_d = dec_imm;
            o_fmt_d = dec_fmt;
            o_ill_d = dec_ill;
         end else begin
            ov_d = 1'b0;
         end
      end else if (in_fire) begin
         sv_d    = 1'b1;
         s_imm_d = dec_imm;
         s_fmt_d = dec_fmt;
         s_ill_d = dec_ill;
      end
   end

   // Output register and skid slot state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ov_q    <= 1'b0;
         o_imm_q <= '0;
         o_fmt_q <= FMT_NONE;
         o_ill_q <= 1'b0;
         sv_q    <= 1'b0;
         s_imm_q <= '0;
         s_fmt_q <= FMT_NONE;
         s_ill_q <= 1'b0;
      end else begin
         ov_q    <= ov_d;
         o_imm_q <= o_imm_d;
         o_fmt_q <= o_fmt_d;
         o_ill_q <= o_ill_d;
         sv_q    <= sv_d;
         s_imm_q <= s_imm_d;
         s_fmt_q <= s_fmt_d;
         s_ill_q <= s_ill_d;
      end
   end

   // Ready tracks next-cycle skid occupancy; held low through reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdy_q <= 1'b0;
      end else begin
         rdy_q <= !sv_d;
      end
   end

   // Saturating count of accepted illegal opcodes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (in_fire && dec_ill && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign in_ready    = rdy_q;
   assign out_valid   = ov_q;
   assign out_imm     = o_imm_q;
   assign out_fmt     = o_fmt_q;
   assign out_illegal = o_ill_q;
   assign err_cnt     = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: vector table, scoreboard queue,
// backpressure, skid, counter saturation and async reset.
module tb_imm_gen_pipe;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } vec_t;

   typedef struct {
      logic [31:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_imm;
   logic [2:0]  out_fmt;
   logic        out_illegal;
   logic [7:0]  err_cnt;

   logic        in_ready64;
   logic        out_valid64;
   logic [63:0] out_imm64;
   logic [2:0]  out_fmt64;
   logic        out_illegal64;
   logic [7:0]  err_cnt64;

   int   total = 0;
   int   bad   = 0;
   int   exp_cnt = 0;
   logic fired = 1'b0;
   logic rand_rdy = 1'b0;

   logic        prev_hold = 1'b0;
   logic [31:0] prev_imm;
   logic [2:0]  prev_fmt;
   logic        prev_ill;

   vec_t tbl [14];
   exp_t q [$];
   exp_t cur_exp;
   exp_t e_ill;

   imm_gen_pipe #(.XLEN(32), .CNT_W(8)) u_dut32 (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_imm     (out_imm),
      .out_fmt     (out_fmt),
      .out_illegal (out_illegal),
      .err_cnt     (err_cnt)
   );

   imm_gen_pipe #(.XLEN(64), .CNT_W(8)) u_dut64 (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready64),
      .in_instr    (in_instr),
      .out_valid   (out_valid64),
      .out_ready   (out_ready),
      .out_imm     (out_imm64),
      .out_fmt     (out_fmt64),
      .out_illegal (out_illegal64),
      .err_cnt     (err_cnt64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t",
                  name, got, want, $time);
      end
   endtask

   task automatic sample();
      exp_t e;
      fired = 1'b0;
      if (reset) begin
         prev_hold = 1'b0;
         return;
      end
      if (prev_hold) begin
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_imm", 64'(out_imm), 64'(prev_imm));
         chk("hold_fmt", 64'(out_fmt), 64'(prev_fmt));
         chk("hold_ill", 64'(out_illegal), 64'(prev_ill));
      end
      if (in_valid && in_ready) begin
         q.push_back(cur_exp);
         fired = 1'b1;
         if (cur_exp.ill && exp_cnt != 255) exp_cnt++;
      end
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_out: got imm %h want none",
                     out_imm);
         end else begin
            e = q.pop_front();
            chk("imm", 64'(out_imm), 64'(e.imm));
            chk("fmt", 64'(out_fmt), 64'(e.fmt));
            chk("ill", 64'(out_illegal), 64'(e.ill));
            chk("imm64", out_imm64, {{32{e.imm[31]}}, e.imm});
         end
      end
      prev_hold = out_valid && !out_ready;
      prev_imm  = out_imm;
      prev_fmt  = out_fmt;
      prev_ill  = out_illegal;
   endtask

   task automatic step();
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] instr, input exp_t e);
      in_valid = 1'b1;
      in_instr = instr;
      cur_exp  = e;
      for (int i = 0; i < 50; i++) begin
         step();
         if (fired) break;
      end
      if (!fired) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got no accept want accept");
      end
      in_valid = 1'b0;
      in_instr = $urandom();
   endtask

   task automatic drain();
      rand_rdy  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 50 && q.size() != 0; i++) step();
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   function automatic exp_t to_exp(input vec_t v);
      exp_t e;
      e.imm = v.imm;
      e.fmt = v.fmt;
      e.ill = v.ill;
      return e;
   endfunction

   initial begin
      tbl[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0};
      tbl[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0};
      tbl[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0};
      tbl[3]  = '{32'h123450B7, 32'h12345000, 3'd4, 1'b0};
      tbl[4]  = '{32'h002081B3, 32'h00000000, 3'd0, 1'b0};
      tbl[5]  = '{32'h008000EF, 32'h00000008, 3'd5, 1'b0};
      tbl[6]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0};
      tbl[7]  = '{32'h01012083, 32'h00000010, 3'd1, 1'b0};
      tbl[8]  = '{32'h7FF08067, 32'h000007FF, 3'd1, 1'b0};
      tbl[9]  = '{32'h00000073, 32'h00000000, 3'd1, 1'b0};
      tbl[10] = '{32'h80000017, 32'h80000000, 3'd4, 1'b0};
      tbl[11] = '{32'h0020A423, 32'h00000008, 3'd2, 1'b0};
      tbl[12] = '{32'h00000863, 32'h00000010, 3'd3, 1'b0};
      tbl[13] = '{32'hFFFFFFFF, 32'h00000000, 3'd7, 1'b1};
      e_ill   = '{32'h0, 3'd7, 1'b1};

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_instr  = 32'h0;
      out_ready = 1'b0;
      cur_exp   = e_ill;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_imm", 64'(out_imm), 64'd0);
      chk("rst_fmt", 64'(out_fmt), 64'd7);
      chk("rst_ill", 64'(out_illegal), 64'd0);
      chk("rst_err", 64'(err_cnt), 64'd0);
      reset = 1'b0;
      chk("rel_ready_low", 64'(in_ready), 64'd0);
      step();
      chk("rel_ready_high", 64'(in_ready), 64'd1);

      out_ready = 1'b1;
      foreach (tbl[i]) send(tbl[i].instr, to_exp(tbl[i]));
      drain();
      chk("err_after_pass1", 64'(err_cnt), 64'(exp_cnt));

      rand_rdy = 1'b1;
      foreach (tbl[i]) send(tbl[i].instr, to_exp(tbl[i]));
      drain();
      chk("err_after_pass2", 64'(err_cnt), 64'(exp_cnt));

      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) send(32'h0000007F, e_ill);
      drain();
      chk("err_sat", 64'(err_cnt), 64'd255);
      chk("err_sat_model", 64'(err_cnt), 64'(exp_cnt));
      chk("err_sat64", 64'(err_cnt64), 64'd255);

      out_ready = 1'b0;
      send(tbl[0].instr, to_exp(tbl[0]));
      send(tbl[1].instr, to_exp(tbl[1]));
      in_valid = 1'b1;
      in_instr = tbl[3].instr;
      cur_exp  = to_exp(tbl[3]);
      repeat (3) step();
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_out_imm", 64'(out_imm), 64'(tbl[0].imm));
      chk("stall_queued", 64'(q.size()), 64'd2);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (fired) break;
      end
      chk("stall_c_taken", 64'(fired), 64'd1);
      in_valid = 1'b0;
      drain();

      out_ready = 1'b0;
      send(tbl[2].instr, to_exp(tbl[2]));
      send(tbl[5].instr, to_exp(tbl[5]));
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      chk("pre_rst_full", 64'(in_ready), 64'd0);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_err", 64'(err_cnt), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd0);
      chk("arst_fmt", 64'(out_fmt), 64'd7);
      chk("arst_imm", 64'(out_imm), 64'd0);
      q.delete();
      exp_cnt   = 0;
      prev_hold = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("arel_ready_low", 64'(in_ready), 64'd0);
      step();
      chk("arel_ready_high", 64'(in_ready), 64'd1);
      chk("arel_out_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      send(tbl[6].instr, to_exp(tbl[6]));
      send(tbl[13].instr, to_exp(tbl[13]));
      drain();
      chk("err_after_rst", 64'(err_cnt), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
